// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic        OP_MUL     = 1'b0;
  localparam logic        OP_DIV     = 1'b1;
  localparam int          ITERATIONS = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFFFFFF;

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational add/subtract shared by the Booth and non-restoring steps.
// Zero latency; no flow control.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/z_muldiv_unit.sv
// Iterative signed MUL (Booth radix-2) / DIV (non-restoring) producing the Z pair; 33 cycles, or 1 for trivial DIV.
// Start is ignored while busy; divider compiled only with ZMULDIV_DIV_EN.
module z_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  state_t           r_state;
  logic [5:0]       r_cnt;
  logic             r_op;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH:0]   r_m;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_zhi;
  logic [WIDTH-1:0] r_zlo;

  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;

`ifdef ZMULDIV_DIV_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_dbz;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // Magnitudes are unsigned, so |-2^31| = 2^31 still fits.
  assign w_abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b = op_b[WIDTH-1] ? -op_b : op_b;
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    w_add_a = r_a;
    w_add_b = '0;
    w_sub   = 1'b0;
    if (r_op == OP_MUL) begin
      case ({r_q[0], r_qm1})
        2'b01:   w_add_b = r_m;
        2'b10: begin
          w_add_b = r_m;
          w_sub   = 1'b1;
        end
        default: w_add_b = '0;
      endcase
    end
`ifdef ZMULDIV_DIV_EN
    else if (r_state == ST_RUN) begin
      w_add_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
      w_add_b = r_m;
      w_sub   = ~r_a[WIDTH];
    end else if (r_a[WIDTH]) begin
      w_add_b = r_m;  // final remainder restore in FIX
    end
`endif
  end

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MUL;
      r_a     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zhi   <= '0;
      r_zlo   <= '0;
`ifdef ZMULDIV_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_op   <= op;
            r_a    <= '0;
            r_qm1  <= 1'b0;
`ifdef ZMULDIV_DIV_EN
            r_dbz  <= 1'b0;
`endif
            if (op == OP_MUL) begin
              r_q     <= op_b;
              r_m     <= {op_a[WIDTH-1], op_a};
              r_state <= ST_RUN;
            end else begin
`ifdef ZMULDIV_DIV_EN
              r_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              r_neg_r <= op_a[WIDTH-1];
              r_m     <= {1'b0, w_abs_b};
              r_dz    <= (op_b == '0);
              // Raw dividend is kept for the divide-by-zero remainder.
              r_q     <= (op_b == '0) ? op_a : w_abs_a;
              r_state <= (op_b == '0) ? ST_FIX : ST_RUN;
`else
              r_state <= ST_FIX;
`endif
            end
          end
        end

        ST_RUN: begin
          r_cnt <= r_cnt + 6'd1;
`ifdef ZMULDIV_DIV_EN
          if (r_op == OP_DIV) begin
            r_a <= w_sum;
            r_q <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          end else
`endif
          begin
            r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_qm1 <= r_q[0];
          end
          if (r_cnt == 6'(ITERATIONS - 1)) r_state <= ST_FIX;
        end

        ST_FIX: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (r_op == OP_MUL) begin
            r_zhi <= r_a[WIDTH-1:0];
            r_zlo <= r_q;
          end else begin
`ifdef ZMULDIV_DIV_EN
            if (r_dz) begin
              r_zhi <= r_q;
              r_zlo <= DIV0_QUOT;
              r_dbz <= 1'b1;
            end else begin
              r_zhi <= r_neg_r ? -w_sum[WIDTH-1:0] : w_sum[WIDTH-1:0];
              r_zlo <= r_neg_q ? -r_q : r_q;
            end
`else
            r_zhi <= '0;
            r_zlo <= '0;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z_hi = r_zhi;
  assign z_lo = r_zlo;

endmodule

// File: tb/tb_z_muldiv_unit.sv
// Randomized bench for z_muldiv_unit against an arithmetic reference; follows ZMULDIV_DIV_EN like the RTL.
module tb_z_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        clear, start, op;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_by_zero;
  logic [31:0] z_hi, z_lo;

  always #5 clk = ~clk;

  z_muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clk),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_hi        (z_hi),
    .z_lo        (z_lo)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain signed arithmetic.
  function automatic void calc(input logic o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo,
                               output logic dz, output int lat);
    longint sa, sb, p;
`ifdef ZMULDIV_DIV_EN
    longint q, r;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    lat = 33;
    hi = '0;
    lo = '0;
    if (o == OP_MUL) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
`ifdef ZMULDIV_DIV_EN
      if (b == 32'd0) begin
        hi  = a;
        lo  = 32'hFFFFFFFF;
        dz  = 1'b1;
        lat = 1;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        hi = r[31:0];
        lo = q[31:0];
      end
`else
      lat = 1;
`endif
    end
  endfunction

  // Cycle-level expectation: result appears 'lat' edges after the accepting edge.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dz;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
  int          m_left = 0, m_lat;

  always @(posedge clk) begin
    if (clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_hi = p_hi; m_lo = p_lo; m_dbz = p_dz;
        end
      end else if (start) begin
        calc(op, op_a, op_b, p_hi, p_lo, p_dz, m_lat);
        m_left = m_lat;
        m_busy = 1'b1;
        m_dbz  = 1'b0;
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
      check("z_hi", z_hi, m_hi);
      check("z_lo", z_lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output int lat, output logic dbz0);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    dbz0  = div_by_zero;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 80) begin
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        op    = 1'($urandom_range(0, 1));
        op_a  = $urandom;
        op_b  = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, required one", lat);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'($urandom_range(0, 15));
      4:       v = -32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  int          lat, ndone, exp_lat;
  logic        d0, e_dz;
  logic [31:0] e_hi, e_lo;

  initial begin
    clear = 1'b1; start = 1'b0; op = OP_MUL; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    check("reset_z_hi", z_hi, 32'd0);
    check("reset_z_lo", z_lo, 32'd0);
    clear = 1'b0;

    // Pin the reference model on hand-computed values.
    calc(OP_MUL, 32'd7, 32'hFFFFFFFD, e_hi, e_lo, e_dz, exp_lat);
    check("model_mul_hi", e_hi, 32'hFFFFFFFF);
    check("model_mul_lo", e_lo, 32'hFFFFFFEB);
`ifdef ZMULDIV_DIV_EN
    calc(OP_DIV, 32'hFFFFFFF9, 32'd2, e_hi, e_lo, e_dz, exp_lat);
    check("model_div_q", e_lo, 32'hFFFFFFFD);
    check("model_div_r", e_hi, 32'hFFFFFFFF);
`endif

    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, lat, d0);
    check("mul1_lat", lat, 32'd33);
    check("mul1_hi", z_hi, 32'hFFFFFFFF);
    check("mul1_lo", z_lo, 32'hFFFFFFEB);

    run_op(OP_MUL, 32'h80000000, 32'h80000000, 1'b0, lat, d0);
    check("mul2_lat", lat, 32'd33);
    check("mul2_hi", z_hi, 32'h40000000);
    check("mul2_lo", z_lo, 32'h00000000);
    @(negedge clk);

`ifdef ZMULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, lat, d0);
    check("div1_lat", lat, 32'd33);
    check("div1_q", z_lo, 32'hFFFFFFFD);
    check("div1_r", z_hi, 32'hFFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, d0);
    check("div2_q", z_lo, 32'h80000000);
    check("div2_r", z_hi, 32'h00000000);
    run_op(OP_DIV, 32'd5, 32'd0, 1'b0, lat, d0);
    check("div0_lat", lat, 32'd1);
    check("div0_flag", {31'b0, div_by_zero}, 32'd1);
    check("div0_q", z_lo, 32'hFFFFFFFF);
    check("div0_r", z_hi, 32'd5);
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, lat, d0);
    check("dbz_cleared_on_start", {31'b0, d0}, 32'd0);
`else
    run_op(OP_DIV, 32'd9, 32'd3, 1'b0, lat, d0);
    check("nodiv_lat", lat, 32'd1);
    check("nodiv_hi", z_hi, 32'd0);
    check("nodiv_lo", z_lo, 32'd0);
    check("nodiv_dbz", {31'b0, div_by_zero}, 32'd0);
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, lat, d0);
    check("nodiv_mul_hi", z_hi, 32'hFFFFFFFF);
    check("nodiv_mul_lo", z_lo, 32'hFFFFFFEB);
`endif
    @(negedge clk);

    // Start, ignored second start at cycle 5, clear at cycle 10.
    start = 1'b1; op = OP_MUL; op_a = 32'd12345; op_b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", {31'b0, busy}, 32'd0);
    check("clr_z_hi", z_hi, 32'd0);
    check("clr_z_lo", z_lo, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("clr_no_done", ndone, 32'd0);

    // Clear beats a simultaneous start.
    clear = 1'b1; start = 1'b1; op = OP_MUL; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clr_vs_start_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic        ro;
      logic [31:0] ra, rb;
      ro = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      calc(ro, ra, rb, e_hi, e_lo, e_dz, exp_lat);
      run_op(ro, ra, rb, 1'b1, lat, d0);
      check("rand_lat", lat, exp_lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
